sram_port0_arbiter: RTL and testbench
=====================================

# sram_port0_arbiter

Owns port 0 (the 1rw port) of the 2 kB 32x512 OpenRAM macro and shares it between two requesters: the Caravel Wishbone slave bus and a word-read requester on the CPU side. It sequences chip select, write enable, write mask, address and write data for the SRAM, captures the read data one cycle after the access, and returns it through a Wishbone ack or a CPU valid pulse. Port 1 (the read-only fetch port) is outside this block's scope.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: Wishbone byte address of SRAM word 0.
- `ADDR_MASK`, default 32'hFFFF_F800: address bits compared against `BASE_ADDR`; this gives a 2 kB window.

Ports (clock and reset first):
- `wb_clk_i` in 1: single clock for all logic; also drives the SRAM `clk0`.
- `rst_n` in 1: asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic control.
- `wbs_sel_i` in 4: byte enables, passed to `wmask0`.
- `wbs_adr_i` in 32: byte address; the word index is `wbs_adr_i[10:2]`.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data.
- `cpu_req_i` in 1: CPU read request, held until granted.
- `cpu_addr_i` in 9: CPU word address.
- `cpu_gnt_o` out 1: one-cycle grant pulse.
- `cpu_rvalid_o` out 1: one-cycle read-data-valid pulse.
- `cpu_rdata_o` out 32: CPU read data.
- `sram_csb0_o`, `sram_web0_o` out 1 each: SRAM chip select and write enable, both active-low.
- `sram_wmask0_o` out 4, `sram_addr0_o` out 9, `sram_din0_o` out 32: SRAM port 0 controls.
- `sram_dout0_i` in 32: SRAM port 0 read data.
- `wr_lock_i` in 1: write lock. Only used when the macro in Configuration is defined.

## Operation
- A Wishbone request is `wbs_cyc_i & wbs_stb_i` with `(wbs_adr_i & ADDR_MASK) == BASE_ADDR`. Requests outside the window are ignored: no ack and no SRAM activity.
- The FSM has four states: IDLE, ACC, CAP, DONE.
- **IDLE**
  - Arbitrate between pending requesters and register the SRAM controls for the winner; go to ACC.
  - If both are pending, the grant is round-robin using a `last_wb` flag.
  - After reset `last_wb=0`, so Wishbone wins the first tie.
- **ACC**
  - `sram_csb0_o=0`. For a write, `sram_web0_o=0` and `wmask0=wbs_sel_i`.
  - For a CPU winner, `cpu_gnt_o=1` for this cycle and `cpu_addr_i` is latched at the ACC entry edge.
  - Reads go to CAP; writes go to DONE.
- **CAP**
  - `csb0` and `web0` are back to 1.
  - `sram_dout0_i` is registered into the data register of the winning requester.
  - Go to DONE.
- **DONE**
  - Wishbone winner: `wbs_ack_o=1`.
  - CPU winner: `cpu_rvalid_o=1`.
  - Go to IDLE.
- Wishbone abort:
  - If `wbs_cyc_i` is low in DONE, the ack is suppressed.
  - The SRAM access has still completed, so a write is performed.
  - Data registers are still updated.
- `wbs_dat_o` and `cpu_rdata_o` hold their last read value until the next read by the same requester. Writes leave `wbs_dat_o` unchanged.
- All SRAM outputs come straight from registers; there is no combinational path from inputs to the SRAM pins.

## Timing
- Reset values:
  - `sram_csb0_o=1`, `sram_web0_o=1`.
  - `sram_wmask0_o=0`, `sram_addr0_o=0`, `sram_din0_o=0`.
  - `wbs_ack_o=0`, `wbs_dat_o=0`.
  - `cpu_gnt_o=0`, `cpu_rvalid_o=0`, `cpu_rdata_o=0`.
  - State IDLE, `last_wb=0`.
- Asserting `rst_n` mid-operation aborts the transaction and forces all reset values immediately, asynchronously. Deassertion is sampled on the `wb_clk_i` rising edge.
- Latency, with the request seen in IDLE in cycle 0:
  - Read: `csb0` low in cycle 1, ack or rvalid in cycle 3.
  - Write: `csb0` low in cycle 1, ack in cycle 2.
- There is one mandatory IDLE cycle between accesses, so sustained read throughput is 1 per 4 cycles.
- If a requester keeps requesting while the other is pending, the two alternate strictly.
- A CPU request that arrives during a Wishbone access waits in `cpu_req_i` and is served at the next IDLE.

## Configuration
- `SRAM_ARB_WRITE_LOCK_EN` defined:
  - A Wishbone write while `wr_lock_i=1` still runs ACC and DONE with normal ack timing.
  - `sram_csb0_o` stays 1 in ACC, so the SRAM is not modified.
- Macro undefined: `wr_lock_i` is ignored and all writes are performed.

## Test plan
- Reset:
  - Drive `rst_n=0` mid-read.
  - Expect `csb0=1`, `ack=0`, `wbs_dat_o=0` immediately, and state IDLE after release.
- Wishbone write then read:
  - Write 0xDEADBEEF to 0x3000_0010 with `sel=4'hF`.
  - Expect `addr0=4`, `web0=0`, `csb0=0` in cycle 1 and ack in cycle 2.
  - Read it back: ack in cycle 3 with `wbs_dat_o=0xDEADBEEF`.
- Out-of-window:
  - Read 0x3000_0800.
  - Expect no ack and `csb0` stuck at 1 for 10 cycles.
- Simultaneous requests:
  - Wishbone read and `cpu_req_i=1` (`cpu_addr_i=9'h1FF`) in the same cycle after reset.
  - Expect Wishbone served first (ack in cycle 3), then `cpu_gnt_o` in cycle 5 and `cpu_rvalid_o` in cycle 7 with the word at 0x1FF.
  - Repeat with both continuously requesting: grants alternate WB, CPU, WB, CPU.
- Abort:
  - Drop `wbs_cyc_i` during CAP of a read.
  - Expect no ack and a return to IDLE in cycle 4.
- Write lock, with `SRAM_ARB_WRITE_LOCK_EN` defined:
  - Write 0x12345678 with `wr_lock_i=1`.
  - Expect ack in cycle 2 and `csb0` never low; a readback returns the old value.

Source files
------------

// File: rtl/sram_port0_arbiter.sv
// rtl/sram_port0_arbiter.sv - port 0 arbiter for the 32x512 OpenRAM macro; optional SRAM_ARB_WRITE_LOCK_EN
module sram_port0_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F800
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        cpu_req_i,
    input  logic [8:0]  cpu_addr_i,
    output logic        cpu_gnt_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    output logic        sram_csb0_o,
    output logic        sram_web0_o,
    output logic [3:0]  sram_wmask0_o,
    output logic [8:0]  sram_addr0_o,
    output logic [31:0] sram_din0_o,
    input  logic [31:0] sram_dout0_i,
    input  logic        wr_lock_i
);

    typedef enum logic [1:0] {IDLE, ACC, CAP, DONE} state_t;

    state_t state, state_nxt;
    logic   last_wb;
    logic   win_wb;
    logic   win_we;
    logic   wb_req;
    logic   grant_wb;
    logic   grant_any;
    logic   wb_wr_grant;
    logic   lock_hit;

    assign wb_req      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    // Round-robin: on a tie the requester that did not win last time goes first.
    assign grant_wb    = wb_req & (~cpu_req_i | ~last_wb);
    assign grant_any   = wb_req | cpu_req_i;
    assign wb_wr_grant = grant_wb & wbs_we_i;

`ifdef SRAM_ARB_WRITE_LOCK_EN
    assign lock_hit = wb_wr_grant & wr_lock_i;
`else
    logic unused_wr_lock;
    assign unused_wr_lock = wr_lock_i;
    assign lock_hit       = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ACC;
            ACC:     state_nxt = win_we ? DONE : CAP;
            CAP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake pulses decode the state; a dropped cyc in DONE suppresses the ack.
    always_comb begin
        wbs_ack_o    = 1'b0;
        cpu_gnt_o    = 1'b0;
        cpu_rvalid_o = 1'b0;
        case (state)
            ACC:  cpu_gnt_o = ~win_wb;
            DONE: begin
                wbs_ack_o    = win_wb & wbs_cyc_i;
                cpu_rvalid_o = ~win_wb;
            end
            default: ;
        endcase
    end

    // SRAM pins are registered at the IDLE->ACC edge and released on every other edge.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            last_wb       <= 1'b0;
            win_wb        <= 1'b0;
            win_we        <= 1'b0;
            sram_csb0_o   <= 1'b1;
            sram_web0_o   <= 1'b1;
            sram_wmask0_o <= 4'h0;
            sram_addr0_o  <= 9'h0;
            sram_din0_o   <= 32'h0;
        end else if (state == IDLE && grant_any) begin
            last_wb       <= grant_wb;
            win_wb        <= grant_wb;
            win_we        <= wb_wr_grant;
            sram_csb0_o   <= lock_hit;
            sram_web0_o   <= ~wb_wr_grant;
            sram_wmask0_o <= wb_wr_grant ? wbs_sel_i : 4'h0;
            sram_addr0_o  <= grant_wb ? wbs_adr_i[10:2] : cpu_addr_i;
            if (wb_wr_grant) begin
                sram_din0_o <= wbs_dat_i;
            end
        end else begin
            sram_csb0_o <= 1'b1;
            sram_web0_o <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wbs_dat_o   <= 32'h0;
            cpu_rdata_o <= 32'h0;
        end else if (state == CAP) begin
            if (win_wb) begin
                wbs_dat_o <= sram_dout0_i;
            end else begin
                cpu_rdata_o <= sram_dout0_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb/tb_sram_port0_arbiter.sv - self-checking bench for sram_port0_arbiter
module tb_sram_port0_arbiter;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef SRAM_ARB_WRITE_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cpu_req_i = 1'b0;
    logic [8:0]  cpu_addr_i = 9'h0;
    logic        cpu_gnt_o, cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        sram_csb0_o, sram_web0_o;
    logic [3:0]  sram_wmask0_o;
    logic [8:0]  sram_addr0_o;
    logic [31:0] sram_din0_o;
    logic [31:0] sram_dout0_i = 32'h0;
    logic        wr_lock_i = 1'b0;

    logic [31:0] sram_mem [0:511] = '{default: 32'h0};
    logic [31:0] ref_mem  [0:511] = '{default: 32'h0};

    int nerr = 0;
    int nchk = 0;

    sram_port0_arbiter dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_gnt_o(cpu_gnt_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o),
        .sram_wmask0_o(sram_wmask0_o), .sram_addr0_o(sram_addr0_o),
        .sram_din0_o(sram_din0_o), .sram_dout0_i(sram_dout0_i),
        .wr_lock_i(wr_lock_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Macro model: synchronous 1rw port with byte write mask.
    always @(posedge wb_clk_i) begin
        if (!sram_csb0_o) begin
            if (!sram_web0_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0_o[b])
                        sram_mem[sram_addr0_o][8*b +: 8] <= sram_din0_o[8*b +: 8];
            end else begin
                sram_dout0_i <= sram_mem[sram_addr0_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [8:0] idx, input logic [31:0] data,
                            input logic [3:0] sel, input bit lock);
        bit locked;
        locked = lock & LOCK_EN;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = sel;
        wbs_adr_i = BASE + {21'h0, idx, 2'b00}; wbs_dat_i = data; wr_lock_i = lock;
        @(negedge wb_clk_i);
        chk("wr_csb", sram_csb0_o, {31'h0, locked});
        chk("wr_web", sram_web0_o, 0);
        chk("wr_addr", sram_addr0_o, idx);
        chk("wr_mask", sram_wmask0_o, sel);
        chk("wr_din", sram_din0_o, data);
        chk("wr_ack_c1", wbs_ack_o, 0);
        @(negedge wb_clk_i);
        chk("wr_ack_c2", wbs_ack_o, 1);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wr_lock_i = 0;
        if (!locked)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic wb_read(input logic [8:0] idx);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + {21'h0, idx, 2'b00};
        @(negedge wb_clk_i);
        chk("rd_csb", sram_csb0_o, 0);
        chk("rd_web", sram_web0_o, 1);
        chk("rd_addr", sram_addr0_o, idx);
        @(negedge wb_clk_i);
        chk("rd_ack_c2", wbs_ack_o, 0);
        @(negedge wb_clk_i);
        chk("rd_ack_c3", wbs_ack_o, 1);
        chk("rd_data", wbs_dat_o, ref_mem[idx]);
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic cpu_read(input logic [8:0] idx);
        @(negedge wb_clk_i);
        cpu_req_i = 1; cpu_addr_i = idx;
        @(negedge wb_clk_i);
        chk("cpu_gnt", cpu_gnt_o, 1);
        chk("cpu_csb", sram_csb0_o, 0);
        chk("cpu_addr", sram_addr0_o, idx);
        cpu_req_i = 0; cpu_addr_i = $urandom_range(0, 511);
        @(negedge wb_clk_i);
        chk("cpu_gnt_c2", cpu_gnt_o, 0);
        chk("cpu_rv_c2", cpu_rvalid_o, 0);
        @(negedge wb_clk_i);
        chk("cpu_rvalid", cpu_rvalid_o, 1);
        chk("cpu_rdata", cpu_rdata_o, ref_mem[idx]);
    endtask

    initial begin
        bit alt_q[$];
        logic [31:0] d;
        // Reset values
        #12;
        chk("rst_csb", sram_csb0_o, 1);
        chk("rst_web", sram_web0_o, 1);
        chk("rst_mask", sram_wmask0_o, 0);
        chk("rst_addr", sram_addr0_o, 0);
        chk("rst_din", sram_din0_o, 0);
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_gnt", cpu_gnt_o, 0);
        chk("rst_rv", cpu_rvalid_o, 0);
        chk("rst_rdata", cpu_rdata_o, 0);
        @(negedge wb_clk_i); rst_n = 1;

        // Write then read back, plus a CPU read of the same word
        wb_write(9'd4, 32'hDEADBEEF, 4'hF, 0);
        wb_read(9'd4);
        wb_write(9'h1FF, 32'hA5C3_0F96, 4'hF, 0);
        cpu_read(9'd4);

        // Out-of-window read is ignored
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0800;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            chk("oow_ack", wbs_ack_o, 0);
            chk("oow_csb", sram_csb0_o, 1);
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;

        // Asynchronous reset in the middle of a read
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = BASE + 32'h10;
        @(negedge wb_clk_i);
        chk("mid_csb_pre", sram_csb0_o, 0);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_csb", sram_csb0_o, 1);
        chk("mid_rst_ack", wbs_ack_o, 0);
        chk("mid_rst_dat", wbs_dat_o, 0);
        chk("mid_rst_rdata", cpu_rdata_o, 0);
        @(negedge wb_clk_i); rst_n = 1; wbs_cyc_i = 0; wbs_stb_i = 0;
        wb_read(9'd4);

        // Simultaneous requests straight after reset: Wishbone first
        @(negedge wb_clk_i); rst_n = 0;
        @(negedge wb_clk_i); rst_n = 1;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h10;
        cpu_req_i = 1; cpu_addr_i = 9'h1FF;
        @(negedge wb_clk_i);
        chk("sim_c1_addr", sram_addr0_o, 4);
        chk("sim_c1_gnt", cpu_gnt_o, 0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("sim_c3_ack", wbs_ack_o, 1);
        chk("sim_c3_dat", wbs_dat_o, ref_mem[4]);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(negedge wb_clk_i);
        chk("sim_c4_gnt", cpu_gnt_o, 0);
        @(negedge wb_clk_i);
        chk("sim_c5_gnt", cpu_gnt_o, 1);
        chk("sim_c5_addr", sram_addr0_o, 9'h1FF);
        cpu_req_i = 0;
        @(negedge wb_clk_i);
        chk("sim_c6_rv", cpu_rvalid_o, 0);
        @(negedge wb_clk_i);
        chk("sim_c7_rv", cpu_rvalid_o, 1);
        chk("sim_c7_rdata", cpu_rdata_o, ref_mem[9'h1FF]);

        // Both requesting continuously: strict alternation starting with Wishbone
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = BASE + 32'h10;
        cpu_req_i = 1; cpu_addr_i = 9'd5;
        for (int i = 1; i < 16; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) alt_q.push_back(1'b1);
            if (cpu_gnt_o) alt_q.push_back(1'b0);
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; cpu_req_i = 0;
        chk("alt_count", alt_q.size(), 4);
        for (int i = 0; i < alt_q.size(); i++)
            chk("alt_order", {31'h0, alt_q[i]}, {31'h0, (i % 2) == 0});

        // Abort: cyc dropped during CAP suppresses the ack but the data lands
        wb_write(9'd9, 32'h0BAD_F00D, 4'hF, 0);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h24;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(negedge wb_clk_i);
        chk("abort_ack", wbs_ack_o, 0);
        chk("abort_dat", wbs_dat_o, ref_mem[9]);
        cpu_read(9'd4);

        // Write lock: ack timing unchanged; memory untouched only when the feature is built in
        wb_write(9'd9, 32'h1234_5678, 4'hF, 1);
        wb_read(9'd9);

        // Randomized traffic against the reference memory
        for (int n = 0; n < 40; n++) begin
            d = $urandom;
            case ($urandom_range(0, 2))
                0:       wb_write(9'($urandom_range(0, 15)), d, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
                1:       wb_read(9'($urandom_range(0, 15)));
                default: cpu_read(9'($urandom_range(0, 15)));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
